// File: rtl/fir_ntap_avg.sv
`default_nettype none
// ============================================================================
// Module      : fir_ntap_avg
// Description : N-tap moving-sum / averaging FIR filter with valid handshake,
//               signed or unsigned operands and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ntap_avg #(
    parameter int W      = 4,
    parameter int TAPS   = 4,
    parameter int SIGNED = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [W-1:0]                a,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [W+$clog2(TAPS)-1:0]   s,
    output logic [W-1:0]                avg,
    output logic                        primed
);

    localparam int LT = $clog2(TAPS);
    localparam int SW = W + LT;
    localparam logic [LT:0] c_full_count = TAPS[LT:0];
    localparam logic [LT:0] c_count_one  = {{LT{1'b0}}, 1'b1};

    logic [W-1:0]  r_ar;
    logic          r_v1;
    logic [W-1:0]  r_d [TAPS];
    logic [SW-1:0] r_sum;
    logic [LT:0]   r_count;
    logic          r_out_valid;

    logic          w_sign_new;
    logic          w_sign_old;
    logic [SW-1:0] w_ext_new;
    logic [SW-1:0] w_ext_old;

    assign w_sign_new = (SIGNED != 0) && r_ar[W-1];
    assign w_sign_old = (SIGNED != 0) && r_d[TAPS-1][W-1];
    assign w_ext_new  = {{LT{w_sign_new}}, r_ar};
    assign w_ext_old  = {{LT{w_sign_old}}, r_d[TAPS-1]};

    // Stage 1: a flush in this cycle kills the incoming sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ar <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_ar <= a;
            r_v1 <= in_valid & ~flush;
        end
    end

    // Stage 2: the sum width W+LT holds TAPS full-scale samples, so no wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (r_v1) begin
            for (int i = TAPS - 1; i > 0; i--) r_d[i] <= r_d[i-1];
            r_d[0]      <= r_ar;
            r_sum       <= r_sum + w_ext_new - w_ext_old;
            r_out_valid <= 1'b1;
            if (r_count != c_full_count) r_count <= r_count + c_count_one;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Upper W bits of the sum are exactly sum >>> LT (floor for signed).
    assign s         = r_sum;
    assign avg       = r_sum[SW-1:LT];
    assign primed    = (r_count == c_full_count);
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_ntap_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_ntap_avg
// Description : Directed and randomised self-checking bench for fir_ntap_avg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_ntap_avg;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic        u_valid = 1'b0;
    logic [3:0]  u_a = '0;
    logic        u_flush = 1'b0;
    logic        u_ov;
    logic [5:0]  u_s;
    logic [3:0]  u_avg;
    logic        u_primed;

    logic        sn_valid = 1'b0;
    logic [3:0]  sn_a = '0;
    logic        sn_flush = 1'b0;
    logic        sn_ov;
    logic [5:0]  sn_s;
    logic [3:0]  sn_avg;
    logic        sn_primed;

    logic        wd_valid = 1'b0;
    logic [15:0] wd_a = '0;
    logic        wd_flush = 1'b0;
    logic        wd_ov;
    logic [18:0] wd_s;
    logic [15:0] wd_avg;
    logic        wd_primed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(0)) dut_u (
        .clk(clk), .reset_n(reset_n), .in_valid(u_valid), .a(u_a), .flush(u_flush),
        .out_valid(u_ov), .s(u_s), .avg(u_avg), .primed(u_primed));

    fir_ntap_avg #(.W(4), .TAPS(4), .SIGNED(1)) dut_sn (
        .clk(clk), .reset_n(reset_n), .in_valid(sn_valid), .a(sn_a), .flush(sn_flush),
        .out_valid(sn_ov), .s(sn_s), .avg(sn_avg), .primed(sn_primed));

    fir_ntap_avg #(.W(16), .TAPS(8), .SIGNED(1)) dut_wd (
        .clk(clk), .reset_n(reset_n), .in_valid(wd_valid), .a(wd_a), .flush(wd_flush),
        .out_valid(wd_ov), .s(wd_s), .avg(wd_avg), .primed(wd_primed));

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive_u(input logic v, input logic [3:0] d, input logic f);
        u_valid = v; u_a = d; u_flush = f;
        @(negedge clk);
    endtask

    task automatic drive_sn(input logic v, input logic [3:0] d, input logic f);
        sn_valid = v; sn_a = d; sn_flush = f;
        @(negedge clk);
    endtask

    task automatic drive_wd(input logic v, input logic [15:0] d, input logic f);
        wd_valid = v; wd_a = d; wd_flush = f;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #2;
        checks++; if (u_s !== 6'd0)    begin failures++; $display("FAIL reset_s got=%0h exp=0", u_s); end
        checks++; if (u_avg !== 4'd0)  begin failures++; $display("FAIL reset_avg got=%0h exp=0", u_avg); end
        checks++; if (u_ov !== 1'b0)   begin failures++; $display("FAIL reset_ov got=%b exp=0", u_ov); end
        checks++; if (u_primed !== 1'b0) begin failures++; $display("FAIL reset_primed got=%b exp=0", u_primed); end
        checks++; if (sn_s !== 6'd0)   begin failures++; $display("FAIL reset_sn_s got=%0h exp=0", sn_s); end
        checks++; if (wd_s !== 19'd0)  begin failures++; $display("FAIL reset_wd_s got=%0h exp=0", wd_s); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_ramp;
        int exp_s[5]   = '{1, 3, 6, 10, 14};
        int exp_avg[5] = '{0, 0, 1, 2, 3};
        logic exp_pr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        drive_u(1'b0, 4'd0, 1'b1);
        for (int t = 0; t < 7; t++) begin
            if (t < 5) drive_u(1'b1, 4'(t + 1), 1'b0);
            else       drive_u(1'b0, 4'd0, 1'b0);
            if (t >= 1 && t <= 5) begin
                checks++; if (u_ov !== 1'b1) begin failures++; $display("FAIL ramp_ov[%0d] got=%b exp=1", t-1, u_ov); end
                checks++; if (u_s !== 6'(exp_s[t-1])) begin failures++; $display("FAIL ramp_s[%0d] got=%0d exp=%0d", t-1, u_s, exp_s[t-1]); end
                checks++; if (u_avg !== 4'(exp_avg[t-1])) begin failures++; $display("FAIL ramp_avg[%0d] got=%0d exp=%0d", t-1, u_avg, exp_avg[t-1]); end
                checks++; if (u_primed !== exp_pr[t-1]) begin failures++; $display("FAIL ramp_primed[%0d] got=%b exp=%b", t-1, u_primed, exp_pr[t-1]); end
            end else if (t == 6) begin
                checks++; if (u_ov !== 1'b0) begin failures++; $display("FAIL ramp_tail_ov got=%b exp=0", u_ov); end
                checks++; if (u_s !== 6'd14) begin failures++; $display("FAIL ramp_tail_s got=%0d exp=14", u_s); end
            end
        end
    endtask

    task automatic test_full_scale;
        int e;
        drive_u(1'b0, 4'd0, 1'b1);
        for (int t = 0; t < 9; t++) begin
            if (t < 8) drive_u(1'b1, 4'd15, 1'b0);
            else       drive_u(1'b0, 4'd0, 1'b0);
            if (t >= 1) begin
                e = (t < 4) ? 15 * t : 60;
                checks++; if (u_s !== 6'(e)) begin failures++; $display("FAIL full_s[%0d] got=%0d exp=%0d", t-1, u_s, e); end
                checks++; if (u_avg !== 4'(e / 4)) begin failures++; $display("FAIL full_avg[%0d] got=%0d exp=%0d", t-1, u_avg, e / 4); end
            end
        end
    endtask

    task automatic test_signed;
        int exp_s[5]   = '{-8, -16, -24, -32, -23};
        int exp_avg[5] = '{-2, -4, -6, -8, -6};
        drive_sn(1'b0, 4'd0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            if (t < 4)       drive_sn(1'b1, 4'h8, 1'b0);
            else if (t == 4) drive_sn(1'b1, 4'h1, 1'b0);
            else             drive_sn(1'b0, 4'h0, 1'b0);
            if (t >= 1) begin
                checks++; if (sn_s !== 6'(exp_s[t-1])) begin failures++; $display("FAIL signed_s[%0d] got=%0d exp=%0d", t-1, $signed(sn_s), exp_s[t-1]); end
                checks++; if (sn_avg !== 4'(exp_avg[t-1])) begin failures++; $display("FAIL signed_avg[%0d] got=%0d exp=%0d", t-1, $signed(sn_avg), exp_avg[t-1]); end
                checks++; if (sn_ov !== 1'b1) begin failures++; $display("FAIL signed_ov[%0d] got=%b exp=1", t-1, sn_ov); end
            end
        end
    endtask

    task automatic test_gaps;
        logic in_v[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int   in_a[6]  = '{3, 0, 0, 5, 0, 0};
        logic exp_ov[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int   exp_s[5]  = '{3, 3, 3, 8, 8};
        int   pulses = 0;
        drive_u(1'b0, 4'd0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            drive_u(in_v[t], 4'(in_a[t]), 1'b0);
            if (t >= 1) begin
                if (u_ov === 1'b1) pulses++;
                checks++; if (u_ov !== exp_ov[t-1]) begin failures++; $display("FAIL gap_ov[%0d] got=%b exp=%b", t-1, u_ov, exp_ov[t-1]); end
                checks++; if (u_s !== 6'(exp_s[t-1])) begin failures++; $display("FAIL gap_s[%0d] got=%0d exp=%0d", t-1, u_s, exp_s[t-1]); end
            end
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_flush_collision;
        drive_u(1'b0, 4'd0, 1'b1);
        for (int t = 0; t < 4; t++) drive_u(1'b1, 4'd7, 1'b0);
        checks++; if (u_s !== 6'd21) begin failures++; $display("FAIL flush_pre_s got=%0d exp=21", u_s); end
        drive_u(1'b1, 4'd9, 1'b1);
        checks++; if (u_s !== 6'd0)    begin failures++; $display("FAIL flush_s got=%0d exp=0", u_s); end
        checks++; if (u_primed !== 1'b0) begin failures++; $display("FAIL flush_primed got=%b exp=0", u_primed); end
        checks++; if (u_ov !== 1'b0)   begin failures++; $display("FAIL flush_ov got=%b exp=0", u_ov); end
        drive_u(1'b0, 4'd0, 1'b0);
        checks++; if (u_ov !== 1'b0 || u_s !== 6'd0) begin failures++; $display("FAIL flush_drop got_ov=%b got_s=%0d exp_ov=0 exp_s=0", u_ov, u_s); end
        drive_u(1'b1, 4'd2, 1'b0);
        drive_u(1'b0, 4'd0, 1'b0);
        checks++; if (u_s !== 6'd2)  begin failures++; $display("FAIL flush_after_s got=%0d exp=2", u_s); end
        checks++; if (u_ov !== 1'b1) begin failures++; $display("FAIL flush_after_ov got=%b exp=1", u_ov); end
    endtask

    task automatic test_async_reset;
        drive_u(1'b0, 4'd0, 1'b1);
        drive_u(1'b1, 4'd5, 1'b0);
        drive_u(1'b1, 4'd6, 1'b0);
        drive_u(1'b1, 4'd7, 1'b0);
        u_valid = 1'b0;
        checks++; if (u_s !== 6'd11) begin failures++; $display("FAIL areset_pre_s got=%0d exp=11", u_s); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (u_s !== 6'd0)    begin failures++; $display("FAIL areset_s got=%0d exp=0", u_s); end
        checks++; if (u_avg !== 4'd0)  begin failures++; $display("FAIL areset_avg got=%0d exp=0", u_avg); end
        checks++; if (u_ov !== 1'b0)   begin failures++; $display("FAIL areset_ov got=%b exp=0", u_ov); end
        checks++; if (u_primed !== 1'b0) begin failures++; $display("FAIL areset_primed got=%b exp=0", u_primed); end
        @(negedge clk);
        reset_n = 1'b1;
        drive_u(1'b1, 4'd4, 1'b0);
        checks++; if (u_ov !== 1'b0) begin failures++; $display("FAIL areset_stale_ov got=%b exp=0", u_ov); end
        drive_u(1'b0, 4'd0, 1'b0);
        checks++; if (u_s !== 6'd4)  begin failures++; $display("FAIL areset_after_s got=%0d exp=4", u_s); end
        checks++; if (u_avg !== 4'd1) begin failures++; $display("FAIL areset_after_avg got=%0d exp=1", u_avg); end
        checks++; if (u_ov !== 1'b1) begin failures++; $display("FAIL areset_after_ov got=%b exp=1", u_ov); end
    endtask

    task automatic test_random_wide;
        int dl[8];
        int msum = 0;
        int last = 0;
        int exp_q[$];
        int e;
        logic v;
        logic [15:0] d;
        for (int i = 0; i < 8; i++) dl[i] = 0;
        drive_wd(1'b0, 16'd0, 1'b1);
        for (int t = 0; t < 1003; t++) begin
            v = (t < 1000) && ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            if (v) begin
                msum = msum + int'($signed(d)) - dl[7];
                for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
                dl[0] = int'($signed(d));
                exp_q.push_back(msum);
            end
            drive_wd(v, d, 1'b0);
            if (wd_ov === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rand_extra_ov got=1 exp=0 at t=%0d", t);
                end else begin
                    e = exp_q.pop_front();
                    last = e;
                    checks++; if (wd_s !== 19'(e)) begin failures++; $display("FAIL rand_s t=%0d got=%0d exp=%0d", t, $signed(wd_s), e); end
                    checks++; if (wd_avg !== 16'(e >>> 3)) begin failures++; $display("FAIL rand_avg t=%0d got=%0d exp=%0d", t, $signed(wd_avg), e >>> 3); end
                end
            end else begin
                checks++; if (wd_s !== 19'(last)) begin failures++; $display("FAIL rand_hold t=%0d got=%0d exp=%0d", t, $signed(wd_s), last); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_missing_ov got=%0d exp=0 pending", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_unsigned_ramp();
        test_full_scale();
        test_signed();
        test_gaps();
        test_flush_collision();
        test_async_reset();
        test_random_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
